// File: rtl/mac_kbd_protocol_pkg.sv
// Shared constants and state encoding for the Mac Plus keyboard protocol responder.
package mac_kbd_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;
    localparam logic [7:0] RSP_KEYPAD  = 8'h79;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INQ_WAIT = 2'd1,
        RESP     = 2'd2
    } kbd_state_e;

endpackage

// File: rtl/mac_kbd_protocol_fifo.sv
// Key-event FIFO: 9-bit entries {keypad, byte}; drops pushes when full, flush empties it.
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     _reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mac_kbd_protocol.sv
// Mac Plus keyboard responder: buffers MCU key events and answers Mac command bytes.
// state    | meaning
// IDLE     | waiting for a command byte from the Mac
// INQ_WAIT | Inquiry pending; answer with first key or null on timeout
// RESP     | Instant/Model/Test answer goes out on the next en tick
module mac_kbd_protocol
    import mac_kbd_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         INQ_TIMEOUT = 2000000,
    parameter logic [7:0] MODEL_ID    = 8'h0B
) (
    input  logic                        clk,
    input  logic                        _reset,
    input  logic                        en,
    input  logic                        kbd_strobe,
    input  logic [9:0]                  kbd_data,
    input  logic [7:0]                  data_out,
    input  logic                        strobe_out,
    output logic [7:0]                  data_in,
    output logic                        strobe_in,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int             TW     = $clog2(INQ_TIMEOUT);
    localparam logic [TW-1:0]  T_LAST = TW'(INQ_TIMEOUT - 1);

    logic [1:0]  strobe_sync_q;
    logic        strobe_dly_q;
    logic        strobe_edge;
    logic        ev_req_q;
    logic [8:0]  ev_data_q;
    logic        unused_kbd_bit9;

    kbd_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        prefix_q, prefix_d;
    logic [7:0]  held_q, held_d;
    logic [7:0]  rsp_q, rsp_d;
    logic        rsp_key_q, rsp_key_d;
    logic [7:0]  data_in_q, data_in_d;
    logic        strobe_in_q, strobe_in_d;

    logic        fifo_pop, fifo_flush;
    logic [8:0]  fifo_head;
    logic        fifo_empty;
    logic        unused_fifo_full;
    logic        key_avail;
    logic [7:0]  key_byte;
    logic        take_key;

    assign unused_kbd_bit9 = kbd_data[9];
    assign strobe_edge     = strobe_sync_q[1] ^ strobe_dly_q;

    // Edge detection runs on every clk so no MCU toggle is missed between en ticks.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            strobe_sync_q <= '0;
            strobe_dly_q  <= 1'b0;
            ev_req_q      <= 1'b0;
            ev_data_q     <= '0;
        end else begin
            strobe_sync_q <= {strobe_sync_q[0], kbd_strobe};
            strobe_dly_q  <= strobe_sync_q[1];
            if (strobe_edge) begin
                ev_req_q  <= 1'b1;
                ev_data_q <= kbd_data[8:0];
            end else if (en) begin
                ev_req_q  <= 1'b0;
            end
        end
    end

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        ._reset    (_reset),
        .push      (en && ev_req_q),
        .push_data (ev_data_q),
        .pop       (en && fifo_pop),
        .flush     (en && fifo_flush),
        .head      (fifo_head),
        .count     (fifo_level),
        .full      (unused_fifo_full),
        .empty     (fifo_empty)
    );

    assign key_avail = prefix_q || !fifo_empty;
    assign key_byte  = prefix_q     ? held_q :
                       fifo_head[8] ? RSP_KEYPAD : fifo_head[7:0];

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        prefix_d    = prefix_q;
        held_d      = held_q;
        rsp_d       = rsp_q;
        rsp_key_d   = rsp_key_q;
        data_in_d   = data_in_q;
        strobe_in_d = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        take_key    = 1'b0;

        case (state_q)
            IDLE: ;
            INQ_WAIT: begin
                if (key_avail) begin
                    take_key = 1'b1;
                    state_d  = IDLE;
                    timer_d  = '0;
                end else if (timer_q == T_LAST) begin
                    data_in_d   = RSP_NULL;
                    strobe_in_d = 1'b1;
                    state_d     = IDLE;
                    timer_d     = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_key_q && key_avail) begin
                    take_key = 1'b1;
                end else begin
                    data_in_d   = rsp_q;
                    strobe_in_d = 1'b1;
                end
                state_d = IDLE;
                timer_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // A new command always wins over whatever answer was about to go out.
        if (strobe_out) begin
            take_key    = 1'b0;
            strobe_in_d = 1'b0;
            data_in_d   = data_in_q;
            timer_d     = '0;
            state_d     = IDLE;
            case (data_out)
                CMD_INQUIRY: state_d = INQ_WAIT;
                CMD_INSTANT: begin
                    state_d   = RESP;
                    rsp_d     = RSP_NULL;
                    rsp_key_d = 1'b1;
                end
                CMD_MODEL: begin
                    state_d    = RESP;
                    rsp_d      = MODEL_ID;
                    rsp_key_d  = 1'b0;
                    prefix_d   = 1'b0;
                    fifo_flush = 1'b1;
                end
                CMD_TEST: begin
                    state_d   = RESP;
                    rsp_d     = RSP_ACK;
                    rsp_key_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (take_key) begin
            data_in_d   = key_byte;
            strobe_in_d = 1'b1;
            if (prefix_q) begin
                prefix_d = 1'b0;
            end else begin
                fifo_pop = 1'b1;
                if (fifo_head[8]) begin
                    held_d   = fifo_head[7:0];
                    prefix_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            prefix_q    <= 1'b0;
            held_q      <= '0;
            rsp_q       <= '0;
            rsp_key_q   <= 1'b0;
            data_in_q   <= '0;
            strobe_in_q <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            prefix_q    <= prefix_d;
            held_q      <= held_d;
            rsp_q       <= rsp_d;
            rsp_key_q   <= rsp_key_d;
            data_in_q   <= data_in_d;
            strobe_in_q <= strobe_in_d;
        end
    end

    assign data_in   = data_in_q;
    assign strobe_in = strobe_in_q;

endmodule
